// File: rtl/la32_defs.sv
// Shared LA32 definitions used by the divider: operand width, op encodings and FSM states.
package la32_defs;

   localparam int DATA_W = 32;

   localparam logic [1:0] DIV_OP_DIVWU = 2'b00;
   localparam logic [1:0] DIV_OP_DIVW  = 2'b01;
   localparam logic [1:0] DIV_OP_MODWU = 2'b10;
   localparam logic [1:0] DIV_OP_MODW  = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: |x| on the operand side, sign restore on the result side.
module div_sign_fix
   import la32_defs::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? -x : x;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu with valid/ready on both sides.
module div_unit
   import la32_defs::*;
#(
   parameter int DATA_W = la32_defs::DATA_W,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        div_op,
   input  logic [DATA_W-1:0] div_src1,
   input  logic [DATA_W-1:0] div_src2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] div_result
);

   div_state_e state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*DATA_W-1:0] rq_q, rq_d;
   logic [DATA_W-1:0]   dvsr_q, dvsr_d;
   logic                sel_rem_q, sel_rem_d;
   logic                qneg_q, qneg_d;
   logic                rneg_q, rneg_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   res_q, res_d;

   logic [1:0][DATA_W-1:0] src_raw, src_abs;
   logic [1:0]             src_neg;

   assign src_raw = {div_src2, div_src1};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_abs
         assign src_neg[gi] = div_op[0] & src_raw[gi][DATA_W-1];
         div_sign_fix #(.W(DATA_W)) u_abs (
            .x   (src_raw[gi]),
            .neg (src_neg[gi]),
            .y   (src_abs[gi])
         );
      end
   endgenerate

   // One restoring step: shift {rem,quo} left, trial-subtract the divisor from the widened remainder.
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W:0]   trial;
   logic              no_borrow;
   logic [DATA_W-1:0] rem_next, quo_next, rem_fixed, quo_fixed;

   assign rem_sh    = rq_q[2*DATA_W-1:DATA_W-1];
   assign trial     = rem_sh - {1'b0, dvsr_q};
   assign no_borrow = ~trial[DATA_W];
   assign rem_next  = no_borrow ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
   assign quo_next  = {rq_q[DATA_W-2:0], no_borrow};

   div_sign_fix #(.W(DATA_W)) u_quo_fix (
      .x   (quo_next),
      .neg (qneg_q),
      .y   (quo_fixed)
   );

   div_sign_fix #(.W(DATA_W)) u_rem_fix (
      .x   (rem_next),
      .neg (rneg_q),
      .y   (rem_fixed)
   );

   logic accept;
   assign accept = in_valid & (state_q == DIV_IDLE) & ~flush;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rq_d        = rq_q;
      dvsr_d      = dvsr_q;
      sel_rem_d   = sel_rem_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;

      case (state_q)
         DIV_IDLE: begin
            out_valid_d = 1'b0;
            if (accept) begin
               sel_rem_d = div_op[1];
               qneg_d    = div_op[0] & (div_src1[DATA_W-1] ^ div_src2[DATA_W-1]);
               rneg_d    = div_op[0] & div_src1[DATA_W-1];
               if (div_src2 == '0) begin
                  res_d   = div_op[1] ? div_src1 : '1;
                  state_d = DIV_DONE;
               end else begin
                  rq_d    = {{DATA_W{1'b0}}, src_abs[0]};
                  dvsr_d  = src_abs[1];
                  cnt_d   = '0;
                  state_d = DIV_BUSY;
               end
            end
         end
         DIV_BUSY: begin
            rq_d  = {rem_next, quo_next};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               res_d   = sel_rem_q ? rem_fixed : quo_fixed;
               cnt_d   = '0;
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            // out_valid rises one cycle after entering DONE and drops on the handshake edge.
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = DIV_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = DIV_IDLE;
         end
      endcase

      if (flush) begin
         state_d     = DIV_IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= DIV_IDLE;
         cnt_q       <= '0;
         rq_q        <= '0;
         dvsr_q      <= '0;
         sel_rem_q   <= 1'b0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rq_q        <= rq_d;
         dvsr_q      <= dvsr_d;
         sel_rem_q   <= sel_rem_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
      end
   end

   assign in_ready   = (state_q == DIV_IDLE);
   assign out_valid  = out_valid_q;
   assign div_result = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed plus random bench for div_unit with an expected-result queue checked at each output.
module tb_div_unit;
   import la32_defs::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  div_op = 2'b00;
   logic [31:0] div_src1 = '0;
   logic [31:0] div_src2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] div_result;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_exp = '0;

   div_unit #(.DATA_W(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .div_op     (div_op),
      .div_src1   (div_src1),
      .div_src2   (div_src2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .div_result (div_result)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Independent reference: 33-bit signed arithmetic covers both signedness and the overflow case.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [32:0] sa, sb, q, r;
      if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
      sa = op[0] ? {a[31], a} : {1'b0, a};
      sb = op[0] ? {b[31], b} : {1'b0, b};
      q  = sa / sb;
      r  = sa % sb;
      return op[1] ? r[31:0] : q[31:0];
   endfunction

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input string tag);
      div_op   = op;
      div_src1 = a;
      div_src2 = b;
      in_valid = 1'b1;
      check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      div_src1 = $urandom;
      div_src2 = $urandom;
      exp_q.push_back(expv);
   endtask

   task automatic collect(input int lat, input string tag);
      int          cyc = 0;
      bit          got = 1'b0;
      bit          rdy_bad = 1'b0;
      logic [31:0] e = 32'hDEAD_BEEF;
      while (!got && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
         if (out_valid) got = 1'b1;
         else if (in_ready) rdy_bad = 1'b1;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(lat));
      check({tag, "_busy_in_ready"}, {31'b0, rdy_bad}, 32'd0);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      last_exp = e;
      check({tag, "_result"}, div_result, e);
      $display("[TB] %s: result=%h expected=%h cycles=%0d", tag, div_result, e, cyc);
   endtask

   task automatic handshake(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_hs_out_valid"}, {31'b0, out_valid}, 32'd0);
      check({tag, "_hs_in_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expv, input int lat, input string tag);
      issue(op, a, b, expv, tag);
      collect(lat, tag);
      handshake(tag);
   endtask

   initial begin
      bit          seen;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", {31'b0, in_ready}, 32'd1);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_result", div_result, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic unsigned
      run(DIV_OP_DIVWU, 32'd7, 32'd2, 32'h3, 33, "divwu_7_2");
      run(DIV_OP_MODWU, 32'd7, 32'd2, 32'h1, 33, "modwu_7_2");
      // Signed sign handling
      run(DIV_OP_DIVW, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "divw_m7_2");
      run(DIV_OP_MODW, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "modw_m7_2");
      run(DIV_OP_DIVW, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "divw_7_m2");
      run(DIV_OP_MODW, 32'd7, 32'hFFFF_FFFE, 32'h1, 33, "modw_7_m2");
      // Boundaries
      run(DIV_OP_DIVW, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "divw_ovf");
      run(DIV_OP_MODW, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, "modw_ovf");
      run(DIV_OP_DIVWU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, "divwu_max_16");
      run(DIV_OP_MODWU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, "modwu_max_16");
      // Divide by zero
      run(DIV_OP_DIVW, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, "divw_by0");
      run(DIV_OP_DIVWU, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, "divwu_by0");
      run(DIV_OP_MODW, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, "modw_by0");
      run(DIV_OP_MODWU, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, "modwu_by0");

      // Backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      issue(DIV_OP_DIVWU, 32'd1000, 32'd7, 32'd142, "hold");
      collect(33, "hold");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_out_valid", {31'b0, out_valid}, 32'd1);
         check("hold_result", div_result, last_exp);
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      run(DIV_OP_MODW, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FFFA, 33, "b2b_after_hold");

      // Flush in the middle of BUSY
      issue(DIV_OP_DIVWU, 32'd5000, 32'd3, 32'd1666, "flush_busy");
      repeat (14) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_in_ready", {31'b0, in_ready}, 32'd1);
      check("flush_out_valid", {31'b0, out_valid}, 32'd0);
      exp_q.delete();
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("flush_no_output", {31'b0, seen}, 32'd0);
      run(DIV_OP_DIVWU, 32'd100, 32'd7, 32'd14, 33, "after_flush_100_7");

      // flush together with in_valid drops the request
      div_op   = DIV_OP_DIVWU;
      div_src1 = 32'd9;
      div_src2 = 32'd0;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flush_drop_in_ready", {31'b0, in_ready}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid || !in_ready) seen = 1'b1;
      end
      check("flush_drop_no_output", {31'b0, seen}, 32'd0);

      // Random operations against the reference model
      for (int i = 0; i < 12; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i == 5) rb = 32'hFFFF_FFFF;
         if (i == 9) rb = 32'h0;
         run(rop, ra, rb, model(rop, ra, rb), (rb == 32'h0) ? 1 : 33, $sformatf("rand%0d", i));
      end

      // Asynchronous reset between edges while BUSY
      issue(DIV_OP_DIVW, 32'hFFFF_0000, 32'd3, 32'h0, "async_rst");
      repeat (10) @(posedge clk);
      #3;
      check("pre_rst_result_nonzero", {31'b0, (div_result == 32'h0)}, 32'd0);
      rst = 1'b1;
      #1;
      check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("async_rst_result", div_result, 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run(DIV_OP_DIVW, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, "after_rst_m100_7");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
